screen_sequencer: RTL and testbench

// Downstream of the menu renderer. Selects between menu_RGB and the game

---
 rtl/screen_pkg.sv | 12 +
 rtl/key_debounce.sv | 33 +++
 rtl/screen_sequencer.sv | 99 +++++++++
 tb/tb_screen_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// screen_pkg: shared state/source types and the per-channel fade helper for the screen sequencer
package screen_pkg;
  typedef enum logic [2:0] {MENU, FADE_OUT, FADE_IN, GAME, OVER} seq_state_t;
  typedef enum logic {SRC_MENU, SRC_GAME} src_t;
  localparam int FADE_STEPS_DEFAULT = 16;
  localparam int FADE_SHIFT = $clog2(FADE_STEPS_DEFAULT);
  function automatic logic [7:0] fade_chan(input logic [7:0] c, input logic [4:0] level, input int shift);
    logic [12:0] p;
    p = {5'b0, c} * {8'b0, level};
    return 8'(p >> shift);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchroniser, stability counter and press pulse for an active-low key
module key_debounce #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  localparam int W = $clog2(CYCLES + 1);
  logic [1:0] sync;
  logic stable;
  logic [W-1:0] cnt;
  logic differ;
  assign differ = sync[1] != stable;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
      stable <= 1'b1;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], key_n};
      press <= 1'b0;
      if (!differ) cnt <= '0;
      else if (cnt == W'(CYCLES - 1)) begin
        stable <= sync[1];
        cnt <= '0;
        press <= !sync[1];
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: menu/game source select with frame-stepped fades and the MENU/GAME/OVER flow
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int FADE_STEPS = FADE_STEPS_DEFAULT,
  parameter int OVER_FRAMES = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x_cnt,
  input  logic [9:0]  y_cnt,
  input  logic [23:0] menu_RGB,
  input  logic [23:0] game_RGB,
  input  logic        start_btn_n,
  input  logic        game_over,
  output logic [23:0] pixel_RGB,
  output logic        game_start,
  output logic        menu_active,
  output logic        in_game
);
  localparam int SHIFT = $clog2(FADE_STEPS);
  localparam int OW = $clog2(OVER_FRAMES + 1);
  localparam logic [4:0] MAX = 5'(FADE_STEPS);
  seq_state_t state, state_n;
  src_t src, src_n;
  logic [4:0] level, level_n;
  logic [OW-1:0] over_cnt, over_n;
  logic gs_n, start_pulse, prev_zero, zero, tick;
  logic [23:0] src_rgb;
  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk(clk),
    .reset(reset),
    .key_n(start_btn_n),
    .press(start_pulse)
  );
  // a stalled (0,0) counter yields only the first-cycle tick
  assign zero = x_cnt == '0 && y_cnt == '0;
  assign tick = zero && !prev_zero;
  assign menu_active = src == SRC_MENU;
  assign in_game = state == GAME;
  assign src_rgb = src == SRC_GAME ? game_RGB : menu_RGB;
  always_comb begin
    state_n = state;
    src_n = src;
    level_n = level;
    over_n = over_cnt;
    gs_n = 1'b0;
    case (state)
      MENU: begin
        src_n = SRC_MENU;
        level_n = MAX;
        if (start_pulse) state_n = FADE_OUT;
      end
      FADE_OUT: if (tick) begin
        level_n = level > 5'd1 ? level - 5'd1 : 5'd0;
        if (level <= 5'd1) begin
          src_n = src == SRC_MENU ? SRC_GAME : SRC_MENU;
          gs_n = src == SRC_MENU;
          state_n = FADE_IN;
        end
      end
      FADE_IN: begin
        if (level >= MAX) state_n = src == SRC_GAME ? GAME : MENU;
        else if (tick) level_n = level + 5'd1;
      end
      GAME: if (game_over) begin
        state_n = OVER;
        over_n = '0;
      end
      OVER: if (tick) begin
        over_n = over_cnt + 1'b1;
        if (over_cnt == OW'(OVER_FRAMES - 1)) state_n = FADE_OUT;
      end
      default: state_n = MENU;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MENU;
      src <= SRC_MENU;
      level <= MAX;
      over_cnt <= '0;
      prev_zero <= 1'b0;
      game_start <= 1'b0;
      pixel_RGB <= '0;
    end else begin
      state <= state_n;
      src <= src_n;
      level <= level_n;
      over_cnt <= over_n;
      prev_zero <= zero;
      game_start <= gs_n;
      pixel_RGB <= {fade_chan(src_rgb[23:16], level, SHIFT),
                    fade_chan(src_rgb[15:8], level, SHIFT),
                    fade_chan(src_rgb[7:0], level, SHIFT)};
    end
  end
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: directed scenario tests of the screen sequencer flow and fade arithmetic
module tb_screen_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [10:0] x_cnt = 11'd1;
  logic [9:0] y_cnt = 10'd0;
  logic [23:0] menu_RGB = 24'h0;
  logic [23:0] game_RGB = 24'h123456;
  logic start_btn_n = 1'b1;
  logic game_over = 1'b0;
  logic [23:0] pixel_RGB;
  logic game_start, menu_active, in_game;
  int passed = 0;
  int total = 0;
  int gs_count = 0;
  screen_sequencer #(.DEBOUNCE_CYCLES(20), .FADE_STEPS(16), .OVER_FRAMES(120)) dut (
    .clk(clk),
    .reset(reset),
    .x_cnt(x_cnt),
    .y_cnt(y_cnt),
    .menu_RGB(menu_RGB),
    .game_RGB(game_RGB),
    .start_btn_n(start_btn_n),
    .game_over(game_over),
    .pixel_RGB(pixel_RGB),
    .game_start(game_start),
    .menu_active(menu_active),
    .in_game(in_game)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (game_start === 1'b1) gs_count++;
  task automatic tick(input int hold);
    @(negedge clk);
    x_cnt = 11'd0;
    y_cnt = 10'd0;
    repeat (hold) @(negedge clk);
    x_cnt = 11'd1;
    @(negedge clk);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1);
  endtask
  task automatic press_key(input int low_cycles);
    @(negedge clk);
    start_btn_n = 1'b0;
    repeat (low_cycles) @(negedge clk);
    start_btn_n = 1'b1;
    repeat (30) @(negedge clk);
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (pixel_RGB !== 24'h0) $display("FAIL reset_pixel got %h want 000000", pixel_RGB); else passed++;
    total++; if ({menu_active, in_game, game_start} !== 3'b100) $display("FAIL reset_flags got %b want 100", {menu_active, in_game, game_start}); else passed++;
    reset = 1'b0;
  endtask
  task automatic test_passthrough;
    menu_RGB = 24'hD85F02;
    @(negedge clk);
    @(negedge clk);
    total++; if (pixel_RGB !== 24'hD85F02) $display("FAIL menu_pass got %h want D85F02", pixel_RGB); else passed++;
    total++; if (menu_active !== 1'b1) $display("FAIL menu_active got %b want 1", menu_active); else passed++;
  endtask
  task automatic test_bounce;
    press_key(10);
    tick(1);
    total++; if (pixel_RGB !== 24'hD85F02) $display("FAIL bounce_level got %h want D85F02", pixel_RGB); else passed++;
    total++; if (gs_count !== 0) $display("FAIL bounce_gs got %0d want 0", gs_count); else passed++;
  endtask
  task automatic test_fade_out;
    menu_RGB = 24'hFFFFFF;
    press_key(25);
    ticks(8);
    total++; if (pixel_RGB !== 24'h7F7F7F) $display("FAIL fade8 got %h want 7F7F7F", pixel_RGB); else passed++;
    tick(4);
    total++; if (pixel_RGB !== 24'h6F6F6F) $display("FAIL stall_tick got %h want 6F6F6F", pixel_RGB); else passed++;
    ticks(6);
    total++; if (gs_count !== 0 || menu_active !== 1'b1) $display("FAIL fade15 got gs=%0d ma=%b want gs=0 ma=1", gs_count, menu_active); else passed++;
    tick(1);
    total++; if (gs_count !== 1) $display("FAIL game_start_once got %0d want 1", gs_count); else passed++;
    total++; if (pixel_RGB !== 24'h0) $display("FAIL fade16 got %h want 000000", pixel_RGB); else passed++;
    total++; if ({menu_active, in_game} !== 2'b00) $display("FAIL switched_src got %b want 00", {menu_active, in_game}); else passed++;
  endtask
  task automatic test_fade_in;
    ticks(5);
    total++; if (pixel_RGB !== 24'h05101A) $display("FAIL fadein5 got %h want 05101A", pixel_RGB); else passed++;
    ticks(11);
    @(negedge clk);
    total++; if (in_game !== 1'b1) $display("FAIL in_game got %b want 1", in_game); else passed++;
    total++; if (pixel_RGB !== 24'h123456) $display("FAIL game_pass got %h want 123456", pixel_RGB); else passed++;
  endtask
  task automatic test_key_in_game;
    press_key(25);
    tick(1);
    total++; if (in_game !== 1'b1 || pixel_RGB !== 24'h123456) $display("FAIL key_in_game got ig=%b px=%h want 1 123456", in_game, pixel_RGB); else passed++;
    total++; if (gs_count !== 1) $display("FAIL key_in_game_gs got %0d want 1", gs_count); else passed++;
  endtask
  task automatic test_over;
    @(negedge clk);
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    @(negedge clk);
    total++; if ({in_game, menu_active} !== 2'b00) $display("FAIL over_entry got %b want 00", {in_game, menu_active}); else passed++;
    ticks(119);
    total++; if (pixel_RGB !== 24'h123456) $display("FAIL over119 got %h want 123456", pixel_RGB); else passed++;
    tick(1);
    total++; if (pixel_RGB !== 24'h123456) $display("FAIL over120 got %h want 123456", pixel_RGB); else passed++;
    tick(1);
    total++; if (pixel_RGB !== 24'h103050) $display("FAIL over_fade1 got %h want 103050", pixel_RGB); else passed++;
    ticks(15);
    total++; if (menu_active !== 1'b1 || pixel_RGB !== 24'h0 || gs_count !== 1) $display("FAIL over_switch got ma=%b px=%h gs=%0d want 1 000000 1", menu_active, pixel_RGB, gs_count); else passed++;
    ticks(16);
    @(negedge clk);
    total++; if (pixel_RGB !== 24'hFFFFFF || in_game !== 1'b0) $display("FAIL back_menu got px=%h ig=%b want FFFFFF 0", pixel_RGB, in_game); else passed++;
    tick(1);
    total++; if (pixel_RGB !== 24'hFFFFFF || menu_active !== 1'b1) $display("FAIL menu_hold got px=%h ma=%b want FFFFFF 1", pixel_RGB, menu_active); else passed++;
  endtask
  task automatic test_reset_mid_fade;
    press_key(25);
    ticks(16);
    total++; if (gs_count !== 2) $display("FAIL second_gs got %0d want 2", gs_count); else passed++;
    ticks(5);
    total++; if (pixel_RGB !== 24'h05101A) $display("FAIL mid_fade5 got %h want 05101A", pixel_RGB); else passed++;
    reset = 1'b1;
    #1;
    total++; if (pixel_RGB !== 24'h0) $display("FAIL async_reset_px got %h want 000000", pixel_RGB); else passed++;
    total++; if ({menu_active, in_game, game_start} !== 3'b100) $display("FAIL async_reset_flags got %b want 100", {menu_active, in_game, game_start}); else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (pixel_RGB !== 24'hFFFFFF) $display("FAIL post_reset_level got %h want FFFFFF", pixel_RGB); else passed++;
    tick(1);
    total++; if (pixel_RGB !== 24'hFFFFFF || gs_count !== 2) $display("FAIL post_reset_menu got px=%h gs=%0d want FFFFFF 2", pixel_RGB, gs_count); else passed++;
  endtask
  initial begin
    test_reset;
    test_passthrough;
    test_bounce;
    test_fade_out;
    test_fade_in;
    test_key_in_game;
    test_over;
    test_reset_mid_fade;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
